// File: rtl/instr_encoder_loader_if.sv
// Beat input and instruction-memory write port of instr_encoder_loader.
// The master drives beats and receives writes; the slave is the encoder.
interface instr_encoder_loader_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_op;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [15:0]       in_imm;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output in_valid, in_op, in_rs, in_rt, in_rd, in_imm,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_op, in_rs, in_rt, in_rd, in_imm,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// Packs mnemonic class + register/immediate fields into MIPS words and
// streams them into instruction memory, one registered write per accepted beat.
module instr_encoder_loader #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  finish,
    instr_encoder_loader_if.slave bus,
    output logic                  busy,
    output logic                  full,
    output logic                  illegal,
    output logic [ADDR_W:0]       count
);
    localparam int unsigned       DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   LAST_CNT = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FULL} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              illegal_q, illegal_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic        legal_op;
    logic        is_rtype;
    logic        is_nop;
    logic [5:0]  code;
    logic [31:0] enc_word;
    logic        ready_c;
    logic        accept;
    logic        wr;

    // code holds the func field for R-type, the primary opcode otherwise
    always_comb begin
        legal_op = 1'b1;
        is_rtype = 1'b0;
        is_nop   = 1'b0;
        code     = '0;
        case (bus.in_op)
            4'd0:  begin is_rtype = 1'b1; code = 6'b100000; end
            4'd1:  begin is_rtype = 1'b1; code = 6'b100010; end
            4'd2:  begin is_rtype = 1'b1; code = 6'b100100; end
            4'd3:  begin is_rtype = 1'b1; code = 6'b100101; end
            4'd4:  begin is_rtype = 1'b1; code = 6'b100110; end
            4'd5:  begin is_rtype = 1'b1; code = 6'b101010; end
            4'd6:  code = 6'b001000;
            4'd7:  code = 6'b001100;
            4'd8:  code = 6'b001101;
            4'd9:  code = 6'b001110;
            4'd10: code = 6'b001010;
            4'd11: code = 6'b100011;
            4'd12: code = 6'b101011;
            4'd13: code = 6'b000100;
            4'd14: is_nop = 1'b1;
            default: legal_op = 1'b0;
        endcase

        if (is_nop || !legal_op) begin
            enc_word = '0;
        end else if (is_rtype) begin
            enc_word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'b00000, code};
        end else begin
            enc_word = {code, bus.in_rs, bus.in_rt, bus.in_imm};
        end
    end

    always_comb begin
        ready_c = (state_q == S_LOAD) && !start && !finish;
        accept  = bus.in_valid && ready_c;
        wr      = accept && legal_op;

        state_d   = state_q;
        ptr_d     = ptr_q;
        count_d   = count_q;
        illegal_d = illegal_q;
        we_d      = wr;
        addr_d    = addr_q;
        wdata_d   = wdata_q;

        if (wr) begin
            addr_d  = ptr_q;
            wdata_d = enc_word;
            ptr_d   = ptr_q + ADDR_W'(1);
            count_d = count_q + (ADDR_W + 1)'(1);
            if (count_q == LAST_CNT) begin
                state_d = S_FULL;
            end
        end
        if (accept && !legal_op) begin
            illegal_d = 1'b1;
        end

        // start wins over finish; neither affects a write already registered
        if (start) begin
            state_d   = S_LOAD;
            ptr_d     = BASE;
            count_d   = '0;
            illegal_d = 1'b0;
        end else if (finish) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ptr_q     <= BASE;
            count_q   <= '0;
            illegal_q <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            count_q   <= count_d;
            illegal_q <= illegal_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign bus.in_ready   = ready_c;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign busy           = (state_q != S_IDLE);
    assign full           = (state_q == S_FULL);
    assign illegal        = illegal_q;
    assign count          = count_q;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Randomized and directed bench for instr_encoder_loader, checked every cycle
// against a behavioural model of the load session and the MIPS field packing.
module tb_instr_encoder_loader;
    localparam int unsigned AW    = 2;
    localparam int unsigned BASE  = 0;
    localparam int unsigned DEPTH = 1 << AW;

    localparam int unsigned FUNC_TAB [6] = '{32, 34, 36, 37, 38, 42};
    localparam int unsigned OPC_TAB  [8] = '{8, 12, 13, 14, 10, 35, 43, 4};

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic start  = 1'b0;
    logic finish = 1'b0;
    logic          busy, full, illegal;
    logic [AW:0]   count;

    instr_encoder_loader_if #(.ADDR_W(AW)) bus ();

    instr_encoder_loader #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .finish  (finish),
        .bus     (bus),
        .busy    (busy),
        .full    (full),
        .illegal (illegal),
        .count   (count)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    function automatic logic [31:0] encode(int unsigned op, int unsigned rs, int unsigned rt,
                                           int unsigned rd, int unsigned imm);
        int unsigned w;
        if (op < 6)       w = (rs << 21) | (rt << 16) | (rd << 11) | FUNC_TAB[op];
        else if (op < 14) w = (OPC_TAB[op - 6] << 26) | (rs << 21) | (rt << 16) | imm;
        else              w = 0;
        return 32'(w);
    endfunction

    // session model: 0 idle, 1 loading, 2 memory full
    int unsigned m_mode = 0;
    int unsigned m_cnt  = 0;
    int unsigned m_ptr  = BASE % DEPTH;
    bit          m_ill  = 1'b0;
    bit          m_we   = 1'b0;
    int unsigned m_addr = 0;
    logic [31:0] m_data = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_cnt = 0; m_ptr = BASE % DEPTH; m_ill = 1'b0;
            m_we = 1'b0; m_addr = 0; m_data = '0;
        end else begin
            bit acc;
            acc  = bus.in_valid && (m_mode == 1) && !start && !finish;
            m_we = 1'b0;
            if (start) begin
                m_mode = 1; m_cnt = 0; m_ptr = BASE % DEPTH; m_ill = 1'b0;
            end else if (finish) begin
                m_mode = 0;
            end else if (acc) begin
                if (bus.in_op == 4'd15) begin
                    m_ill = 1'b1;
                end else begin
                    m_we   = 1'b1;
                    m_addr = m_ptr;
                    m_data = encode(bus.in_op, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_imm);
                    m_ptr  = (m_ptr + 1) % DEPTH;
                    m_cnt  = m_cnt + 1;
                    if (m_cnt == DEPTH) m_mode = 2;
                end
            end
        end
    end

    // literal expectations posted by the directed sequence
    bit          lit_on = 1'b0;
    bit          lit_we, lit_busy, lit_full, lit_ill, lit_ready;
    int unsigned lit_addr, lit_cnt;
    logic [31:0] lit_data;
    bit          pinned = 1'b0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got 0x%08h, want 0x%08h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!pinned) begin
            pinned = 1'b1;
            check("pin_add",  encode(0, 1, 2, 3, 0),       32'h00221820);
            check("pin_lw",   encode(11, 29, 8, 0, 4),     32'h8FA80004);
            check("pin_beq",  encode(13, 4, 5, 0, 'hFFFE), 32'h1085FFFE);
            check("pin_sw",   encode(12, 2, 3, 0, 'h10),   32'hAC430010);
            check("pin_slt",  encode(5, 7, 8, 9, 0),       32'h00E8482A);
            check("pin_addi", encode(6, 1, 2, 31, 5),      32'h20220005);
        end
        check("in_ready",   32'(bus.in_ready),  32'((m_mode == 1) && !start && !finish));
        check("imem_we",    32'(bus.imem_we),   32'(m_we));
        check("imem_addr",  32'(bus.imem_addr), m_addr);
        check("imem_wdata", bus.imem_wdata,     m_data);
        check("busy",       32'(busy),          32'(m_mode != 0));
        check("full",       32'(full),          32'(m_mode == 2));
        check("illegal",    32'(illegal),       32'(m_ill));
        check("count",      32'(count),         m_cnt);
        if (lit_on) begin
            check("lit_we",    32'(bus.imem_we),   32'(lit_we));
            check("lit_addr",  32'(bus.imem_addr), lit_addr);
            check("lit_data",  bus.imem_wdata,     lit_data);
            check("lit_count", 32'(count),         lit_cnt);
            check("lit_busy",  32'(busy),          32'(lit_busy));
            check("lit_full",  32'(full),          32'(lit_full));
            check("lit_ill",   32'(illegal),       32'(lit_ill));
            check("lit_ready", 32'(bus.in_ready),  32'(lit_ready));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(bit v, int unsigned op, int unsigned rs, int unsigned rt,
                        int unsigned rd, int unsigned imm);
        bus.in_valid = v;
        bus.in_op    = 4'(op);
        bus.in_rs    = 5'(rs);
        bus.in_rt    = 5'(rt);
        bus.in_rd    = 5'(rd);
        bus.in_imm   = 16'(imm);
    endtask

    task automatic lit(bit we, int unsigned addr, logic [31:0] data, int unsigned cnt,
                       bit b, bit f, bit il, bit rdy);
        lit_on = 1'b1; lit_we = we; lit_addr = addr; lit_data = data; lit_cnt = cnt;
        lit_busy = b; lit_full = f; lit_ill = il; lit_ready = rdy;
    endtask

    initial begin
        beat(0, 0, 0, 0, 0, 0);
        repeat (2) cyc();
        lit(0, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        rst_n = 1'b1;
        lit_on = 1'b0;
        cyc();

        // R-type encode
        start = 1'b1; cyc(); start = 1'b0;
        beat(1, 0, 1, 2, 3, 0); cyc();
        beat(0, 0, 0, 0, 0, 0); lit(1, 0, 32'h00221820, 1, 1, 0, 0, 1); cyc();
        lit_on = 1'b0;

        // back-to-back I-type
        start = 1'b1; cyc(); start = 1'b0;
        beat(1, 11, 29, 8, 0, 'h0004); cyc();
        beat(1, 13, 4, 5, 0, 'hFFFE); lit(1, 0, 32'h8FA80004, 1, 1, 0, 0, 1); cyc();
        beat(0, 0, 0, 0, 0, 0); lit(1, 1, 32'h1085FFFE, 2, 1, 0, 0, 1); cyc();
        lit_on = 1'b0;

        // fill boundary: five beats offered, four fit
        start = 1'b1; cyc(); start = 1'b0;
        beat(1, 6, 1, 2, 31, 5);
        repeat (3) cyc();
        cyc(); lit(1, 3, 32'h20220005, 4, 1, 1, 0, 0);
        cyc(); lit(0, 3, 32'h20220005, 4, 1, 1, 0, 0);
        beat(0, 0, 0, 0, 0, 0); finish = 1'b1; cyc(); finish = 1'b0;
        lit(0, 3, 32'h20220005, 4, 0, 0, 0, 0); cyc();
        lit_on = 1'b0;

        // illegal op between two ADDI beats
        start = 1'b1; cyc(); start = 1'b0;
        beat(1, 6, 3, 4, 0, 'h0010); cyc();
        beat(1, 15, 9, 9, 9, 'h1234); lit(1, 0, 32'h20640010, 1, 1, 0, 0, 1); cyc();
        beat(1, 6, 5, 6, 0, 'hFFFF); lit(0, 0, 32'h20640010, 1, 1, 0, 1, 1); cyc();
        beat(0, 0, 0, 0, 0, 0); lit(1, 1, 32'h20A6FFFF, 2, 1, 0, 1, 1); cyc();
        lit_on = 1'b0; start = 1'b1; cyc(); start = 1'b0;
        lit(0, 1, 32'h20A6FFFF, 0, 1, 0, 0, 1); cyc();

        // valid with finish, then valid with start
        beat(1, 0, 1, 1, 1, 0); finish = 1'b1;
        lit(0, 1, 32'h20A6FFFF, 0, 1, 0, 0, 0); cyc();
        finish = 1'b0; beat(0, 0, 0, 0, 0, 0);
        lit(0, 1, 32'h20A6FFFF, 0, 0, 0, 0, 0); cyc();
        lit_on = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        beat(1, 0, 1, 1, 1, 0); cyc();
        start = 1'b1; lit(1, 0, 32'h00210820, 1, 1, 0, 0, 0); cyc();
        start = 1'b0; beat(1, 12, 2, 3, 0, 'h10);
        lit(0, 0, 32'h00210820, 0, 1, 0, 0, 1); cyc();
        beat(0, 0, 0, 0, 0, 0); lit(1, 0, 32'hAC430010, 1, 1, 0, 0, 1); cyc();
        lit_on = 1'b0;

        // reset right after an acceptance drops the pending write
        beat(1, 0, 1, 2, 3, 0); cyc();
        beat(0, 0, 0, 0, 0, 0); rst_n = 1'b0;
        lit(0, 0, 32'h0, 0, 0, 0, 0, 0); cyc();
        cyc();
        rst_n = 1'b1; beat(1, 0, 1, 2, 3, 0); cyc();
        cyc();
        lit_on = 1'b0;

        // randomized sessions
        for (int i = 0; i < 2000; i++) begin
            start  = ($urandom_range(0, 19) == 0);
            finish = ($urandom_range(0, 29) == 0);
            beat($urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 31),
                 $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 65535));
            rst_n = ($urandom_range(0, 399) != 0);
            cyc();
        end
        start = 1'b0; finish = 1'b0; rst_n = 1'b1;
        beat(0, 0, 0, 0, 0, 0);
        repeat (3) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
